branch_checkpoint_table: RTL



---
 rtl/branch_checkpoint_if.sv | 47 ++++
 rtl/branch_checkpoint_table.sv | 123 ++++++++++++
 2 files changed

// File: rtl/branch_checkpoint_if.sv
// Bundle between rename/dispatch, branch_misprediction and the branch checkpoint table.
// The master drives allocate/resolve/recovery requests; the slave is the table itself.
interface branch_checkpoint_if #(
  parameter int BRANCH_NUM       = 4,
  parameter int REG_NUM          = 32,
  parameter int PHYS_REG_NUM     = 64,
  parameter int ACTIVE_LIST_SIZE = 64
) ();
  localparam int BN_IDX = $clog2(BRANCH_NUM);
  localparam int PR_IDX = $clog2(PHYS_REG_NUM);
  localparam int AL_IDX = $clog2(ACTIVE_LIST_SIZE);

  // Allocation handshake: a checkpoint is taken on a clock edge where
  // alloc_valid && alloc_ready; alloc_valid may be held while alloc_ready is low.
  logic                               alloc_valid;
  logic                               alloc_ready;
  logic [AL_IDX-1:0]                  alloc_branch_id;
  logic [PR_IDX-1:0]                  alloc_free_head;
  logic [REG_NUM*PR_IDX-1:0]          alloc_rename_map;
  logic                               ds_set;
  logic                               resolve_valid;
  logic [AL_IDX-1:0]                  resolve_branch_id;
  logic                               mispredict;
  logic [BRANCH_NUM-1:0]              recov_valid;
  logic [BN_IDX-1:0]                  recov_write_pointer;
  logic [BRANCH_NUM-1:0]              valid;
  logic [BN_IDX-1:0]                  write_pointer;
  logic [BRANCH_NUM*AL_IDX-1:0]       branch_id;
  logic [BRANCH_NUM*PR_IDX-1:0]       free_head_pointer;
  logic [BRANCH_NUM*REG_NUM*PR_IDX-1:0] rename_buffer;
  logic [BRANCH_NUM-1:0]              ds_valid;
  logic                               full;

  modport master (
    output alloc_valid, alloc_branch_id, alloc_free_head, alloc_rename_map, ds_set,
           resolve_valid, resolve_branch_id, mispredict, recov_valid, recov_write_pointer,
    input  alloc_ready, valid, write_pointer, branch_id, free_head_pointer,
           rename_buffer, ds_valid, full
  );

  modport slave (
    input  alloc_valid, alloc_branch_id, alloc_free_head, alloc_rename_map, ds_set,
           resolve_valid, resolve_branch_id, mispredict, recov_valid, recov_write_pointer,
    output alloc_ready, valid, write_pointer, branch_id, free_head_pointer,
           rename_buffer, ds_valid, full
  );
endinterface

// File: rtl/branch_checkpoint_table.sv
// One rename checkpoint per in-flight branch, restored from branch_misprediction on a flush.
// Optional CHECKPOINT_STATS_EN adds saturating allocation/stall/flush counters.
module branch_checkpoint_table #(
  parameter int BRANCH_NUM       = 4,
  parameter int REG_NUM          = 32,
  parameter int PHYS_REG_NUM     = 64,
  parameter int ACTIVE_LIST_SIZE = 64
) (
  input  logic               clk,
  input  logic               rst,
  branch_checkpoint_if.slave bus,
  output logic               state_dbg_o
`ifdef CHECKPOINT_STATS_EN
  ,
  output logic [31:0]        stat_allocs,
  output logic [31:0]        stat_full_stalls,
  output logic [31:0]        stat_flushes
`endif
);
  localparam int BN_IDX = $clog2(BRANCH_NUM);
  localparam int PR_IDX = $clog2(PHYS_REG_NUM);
  localparam int AL_IDX = $clog2(ACTIVE_LIST_SIZE);
  localparam int MAP_W  = REG_NUM * PR_IDX;

  typedef enum logic [0:0] {NORMAL = 1'b0, RECOVER = 1'b1} state_e;

  state_e                  state_q;
  logic [BRANCH_NUM-1:0]   valid_q, valid_d;
  logic [BRANCH_NUM-1:0]   ds_valid_q, ds_valid_d;
  logic [BN_IDX-1:0]       wp_q, wp_d;
  logic [AL_IDX-1:0]       bid_q [BRANCH_NUM];
  logic [PR_IDX-1:0]       fh_q  [BRANCH_NUM];
  logic [MAP_W-1:0]        map_q [BRANCH_NUM];

  logic                    ready;
  logic                    alloc_fire;
  logic [BN_IDX-1:0]       ds_idx;

  assign ready       = !rst && (state_q == NORMAL) && !valid_q[wp_q] && !bus.mispredict;
  assign alloc_fire  = bus.alloc_valid && ready;
  // The newest checkpoint sits just behind the write pointer.
  assign ds_idx      = wp_q - BN_IDX'(1);
  assign state_dbg_o = state_q;

  always_comb begin
    valid_d    = valid_q;
    ds_valid_d = ds_valid_q;
    wp_d       = wp_q;
    if (bus.ds_set && valid_q[ds_idx]) ds_valid_d[ds_idx] = 1'b1;
    if (bus.resolve_valid) begin
      for (int i = 0; i < BRANCH_NUM; i++) begin
        if (valid_q[i] && (bid_q[i] == bus.resolve_branch_id)) valid_d[i] = 1'b0;
      end
    end
    if (alloc_fire) begin
      valid_d[wp_q]    = 1'b1;
      ds_valid_d[wp_q] = 1'b0;
      wp_d             = wp_q + BN_IDX'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= NORMAL;
      valid_q    <= '0;
      ds_valid_q <= '0;
      wp_q       <= '0;
      for (int i = 0; i < BRANCH_NUM; i++) begin
        bid_q[i] <= '0;
        fh_q[i]  <= '0;
        map_q[i] <= '0;
      end
    end else if (bus.mispredict) begin
      state_q    <= RECOVER;
      valid_q    <= bus.recov_valid;
      wp_q       <= bus.recov_write_pointer;
      ds_valid_q <= ds_valid_q & bus.recov_valid;
    end else begin
      state_q    <= NORMAL;
      valid_q    <= valid_d;
      ds_valid_q <= ds_valid_d;
      wp_q       <= wp_d;
      if (alloc_fire) begin
        bid_q[wp_q] <= bus.alloc_branch_id;
        fh_q[wp_q]  <= bus.alloc_free_head;
        map_q[wp_q] <= bus.alloc_rename_map;
      end
    end
  end

  assign bus.alloc_ready   = ready;
  assign bus.valid         = valid_q;
  assign bus.ds_valid      = ds_valid_q;
  assign bus.write_pointer = wp_q;
  assign bus.full          = valid_q[wp_q];

  for (genvar g = 0; g < BRANCH_NUM; g++) begin : g_flat
    assign bus.branch_id[g*AL_IDX +: AL_IDX]         = bid_q[g];
    assign bus.free_head_pointer[g*PR_IDX +: PR_IDX] = fh_q[g];
    assign bus.rename_buffer[g*MAP_W +: MAP_W]       = map_q[g];
  end

`ifdef CHECKPOINT_STATS_EN
  logic [31:0] allocs_q, stalls_q, flushes_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      allocs_q  <= '0;
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      if (alloc_fire && !(&allocs_q)) allocs_q <= allocs_q + 32'd1;
      if (bus.alloc_valid && valid_q[wp_q] && (state_q == NORMAL) && !(&stalls_q))
        stalls_q <= stalls_q + 32'd1;
      if (bus.mispredict && !(&flushes_q)) flushes_q <= flushes_q + 32'd1;
    end
  end

  assign stat_allocs      = allocs_q;
  assign stat_full_stalls = stalls_q;
  assign stat_flushes     = flushes_q;
`endif
endmodule
